// File: rtl/trigger_pkg.sv
// Definitions shared between the trigger top and its mode-selection front end.
package trigger_pkg;

  localparam int NUM_TRIG_MODES = 5;

  typedef enum logic [2:0] {
    MODE_IDLE = 3'd0,
    MODE_SEQ  = 3'd1,
    MODE_COMB = 3'd2,
    MODE_TIME = 3'd3,
    MODE_EDGE = 3'd4
  } mode_e;

  typedef enum logic [1:0] {
    RELEASED     = 2'd0,
    WAIT_PRESS   = 2'd1,
    PRESSED      = 2'd2,
    WAIT_RELEASE = 2'd3
  } deb_state_e;

endpackage

// File: rtl/btn_debounce.sv
// Two-flop synchroniser and debounce FSM for a raw push-button.
// press_pulse is high in the cycle whose closing edge moves WAIT_PRESS -> PRESSED.
module btn_debounce
  import trigger_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 240000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic sw2,
  output logic press_pulse,
  output logic level_pressed
);

  localparam int CNT_W = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
  // The transition edge is the one on which the count would reach DEBOUNCE_CYCLES-1,
  // so the counter never holds more than DEBOUNCE_CYCLES-2 and cannot wrap.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 2);

  logic             sw_meta;
  logic             sw_sync;
  deb_state_e       state_q;
  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sw_meta <= 1'b0;
      sw_sync <= 1'b0;
    end else begin
      sw_meta <= sw2;
      sw_sync <= sw_meta;
    end
  end

  assign press_pulse   = (state_q == WAIT_PRESS) && sw_sync && (cnt_q == CNT_LAST);
  assign level_pressed = (state_q == PRESSED) || (state_q == WAIT_RELEASE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= RELEASED;
      cnt_q   <= '0;
    end else begin
      case (state_q)
        RELEASED: begin
          cnt_q <= '0;
          if (sw_sync) state_q <= WAIT_PRESS;
        end
        WAIT_PRESS: begin
          if (!sw_sync) begin
            state_q <= RELEASED;
            cnt_q   <= '0;
          end else if (cnt_q == CNT_LAST) begin
            state_q <= PRESSED;
            cnt_q   <= '0;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        PRESSED: begin
          cnt_q <= '0;
          if (!sw_sync) state_q <= WAIT_RELEASE;
        end
        WAIT_RELEASE: begin
          if (sw_sync) begin
            state_q <= PRESSED;
            cnt_q   <= '0;
          end else if (cnt_q == CNT_LAST) begin
            state_q <= RELEASED;
            cnt_q   <= '0;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: begin
          state_q <= RELEASED;
          cnt_q   <= '0;
        end
      endcase
    end
  end

endmodule

// File: rtl/mode_select_ctrl.sv
// Wrap-around mode selector driven by a debounced push-button, with one-hot engine enables.
// Define MODE_SELECT_LONG_PRESS_EN to make a long hold force the mode back to 0.
module mode_select_ctrl
  import trigger_pkg::*;
#(
  parameter  int NUM_MODES         = NUM_TRIG_MODES,
  parameter  int DEBOUNCE_CYCLES   = 240000,
  parameter  int LONG_PRESS_CYCLES = 12000000,
  localparam int STATE_W           = $clog2(NUM_MODES)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 sw2,
  output logic [STATE_W-1:0]   state_o,
  output logic [NUM_MODES-1:0] active_o,
  output logic                 press_pulse_o
);

  logic               press_accept;
  logic               level_pressed;
  logic               long_fire;
  logic [STATE_W-1:0] state_nxt;

  btn_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_debounce (
    .clk          (clk),
    .rst_n        (rst_n),
    .sw2          (sw2),
    .press_pulse  (press_accept),
    .level_pressed(level_pressed)
  );

`ifdef MODE_SELECT_LONG_PRESS_EN
  localparam int HOLD_W = (LONG_PRESS_CYCLES > 2) ? $clog2(LONG_PRESS_CYCLES) : 1;
  localparam logic [HOLD_W-1:0] HOLD_FIRE = HOLD_W'(LONG_PRESS_CYCLES - 2);
  localparam logic [HOLD_W-1:0] HOLD_SAT  = HOLD_W'(LONG_PRESS_CYCLES - 1);

  logic [HOLD_W-1:0] hold_q;

  // Fires on the edge that takes the count to its saturation value, hence once per hold.
  assign long_fire = level_pressed && (hold_q == HOLD_FIRE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                 hold_q <= '0;
    else if (!level_pressed)    hold_q <= '0;
    else if (hold_q != HOLD_SAT) hold_q <= hold_q + 1'b1;
  end
`else
  localparam int unused_long_press_cycles = LONG_PRESS_CYCLES;
  logic unused_level_pressed;

  // Hold duration has no effect in this build.
  assign unused_level_pressed = level_pressed;
  assign long_fire            = 1'b0;
`endif

  always_comb begin
    state_nxt = state_o;
    if (32'(state_o) >= NUM_MODES)
      state_nxt = '0;
    else if (long_fire)
      state_nxt = '0;
    else if (press_accept)
      state_nxt = (32'(state_o) == NUM_MODES - 1) ? '0 : state_o + 1'b1;
  end

  // Index and one-hot are loaded from the same next value so they always agree.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_o       <= '0;
      active_o      <= NUM_MODES'(1);
      press_pulse_o <= 1'b0;
    end else begin
      state_o       <= state_nxt;
      active_o      <= NUM_MODES'(1) << state_nxt;
      press_pulse_o <= press_accept;
    end
  end

endmodule

// File: tb/tb_mode_select_ctrl.sv
// Directed bench for mode_select_ctrl: reset, clean press, bounce, wrap, async reset, long hold.
module tb_mode_select_ctrl;

  localparam int NUM_MODES = 5;
  localparam int DEB       = 4;
  localparam int LONGP     = 16;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       sw2;
  logic [2:0] state_o;
  logic [4:0] active_o;
  logic       press_pulse_o;

  int cyc    = 0;
  int pulses = 0;
  int last_pulse_cyc = -1;
  int total  = 0;
  int passed = 0;
  int k;
  int p0;

  mode_select_ctrl #(
    .NUM_MODES        (NUM_MODES),
    .DEBOUNCE_CYCLES  (DEB),
    .LONG_PRESS_CYCLES(LONGP)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .sw2          (sw2),
    .state_o      (state_o),
    .active_o     (active_o),
    .press_pulse_o(press_pulse_o)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (rst_n && press_pulse_o) begin
      pulses         <= pulses + 1;
      last_pulse_cyc <= cyc;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic press_release();
    sw2 = 1'b1;
    cycles(10);
    sw2 = 1'b0;
    cycles(10);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    cycles(3);
    rst_n = 1'b1;
    cycles(1);
  endtask

  initial begin
    rst_n = 1'b0;
    sw2   = 1'b0;
    #1;
    chk("reset_state_in_reset", 32'(state_o), 32'd0);
    cycles(3);
    chk("reset_active_in_reset", 32'(active_o), 32'b00001);
    rst_n = 1'b1;
    cycles(1);
    chk("reset_state_after", 32'(state_o), 32'd0);
    chk("reset_pulse_after", 32'(press_pulse_o), 32'd0);
    cycles(20);
    chk("idle_state_20", 32'(state_o), 32'd0);
    chk("idle_active_20", 32'(active_o), 32'b00001);
    chk("idle_no_pulse", 32'(pulses), 32'd0);

    // Clean press
    k   = cyc;
    sw2 = 1'b1;
    cycles(10);
    chk("clean_pulse_count", 32'(pulses), 32'd1);
    chk("clean_latency_ok", 32'((last_pulse_cyc - k) inside {[5:7]}), 32'd1);
    chk("clean_state", 32'(state_o), 32'd1);
    chk("clean_active", 32'(active_o), 32'b00010);
    sw2 = 1'b0;
    cycles(10);
    chk("release_pulse_count", 32'(pulses), 32'd1);
    chk("release_state", 32'(state_o), 32'd1);

    // Press bounce shorter than the debounce window
    sw2 = 1'b1; cycles(2);
    sw2 = 1'b0; cycles(2);
    sw2 = 1'b1; cycles(2);
    sw2 = 1'b0; cycles(12);
    chk("bounce_pulse_count", 32'(pulses), 32'd1);
    chk("bounce_state", 32'(state_o), 32'd1);

    // Valid press followed by a bouncy release
    sw2 = 1'b1; cycles(10);
    chk("press2_state", 32'(state_o), 32'd2);
    sw2 = 1'b0; cycles(2);
    sw2 = 1'b1; cycles(2);
    sw2 = 1'b0; cycles(2);
    sw2 = 1'b1; cycles(2);
    sw2 = 1'b0; cycles(12);
    chk("rel_bounce_pulse_count", 32'(pulses), 32'd2);
    chk("rel_bounce_state", 32'(state_o), 32'd2);
    chk("rel_bounce_active", 32'(active_o), 32'b00100);

    // Wrap-around from reset
    do_reset();
    chk("wrap_reset_state", 32'(state_o), 32'd0);
    press_release(); chk("wrap_s1", 32'(state_o), 32'd1); chk("wrap_a1", 32'(active_o), 32'b00010);
    press_release(); chk("wrap_s2", 32'(state_o), 32'd2); chk("wrap_a2", 32'(active_o), 32'b00100);
    press_release(); chk("wrap_s3", 32'(state_o), 32'd3); chk("wrap_a3", 32'(active_o), 32'b01000);
    press_release(); chk("wrap_s4", 32'(state_o), 32'd4); chk("wrap_a4", 32'(active_o), 32'b10000);
    press_release(); chk("wrap_s0", 32'(state_o), 32'd0); chk("wrap_a0", 32'(active_o), 32'b00001);
    chk("wrap_pulse_count", 32'(pulses), 32'd7);

    // Asynchronous reset in the middle of WAIT_PRESS with state 3
    press_release(); press_release(); press_release();
    chk("mid_pre_state", 32'(state_o), 32'd3);
    sw2 = 1'b1;
    cycles(4);
    rst_n = 1'b0;
    #1;
    chk("mid_async_state", 32'(state_o), 32'd0);
    chk("mid_async_active", 32'(active_o), 32'b00001);
    cycles(2);
    p0    = pulses;
    rst_n = 1'b1;
    cycles(12);
    chk("mid_after_state", 32'(state_o), 32'd1);
    chk("mid_after_pulses", 32'(pulses - p0), 32'd1);
    sw2 = 1'b0;
    cycles(10);

    // Long hold starting from state 2
    press_release();
    chk("long_pre_state", 32'(state_o), 32'd2);
    p0  = pulses;
    sw2 = 1'b1;
    cycles(7);
    chk("long_accept_state", 32'(state_o), 32'd3);
    cycles(23);
`ifdef MODE_SELECT_LONG_PRESS_EN
    chk("long_hold_state", 32'(state_o), 32'd0);
    chk("long_hold_active", 32'(active_o), 32'b00001);
`else
    chk("long_hold_state", 32'(state_o), 32'd3);
    chk("long_hold_active", 32'(active_o), 32'b01000);
`endif
    chk("long_hold_pulses", 32'(pulses - p0), 32'd1);
    sw2 = 1'b0;
    cycles(10);
    chk("long_release_pulses", 32'(pulses - p0), 32'd1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
